// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  mips_pkg
//  Opcode/funct encodings, pipeline-control FSM states and decode helpers.
//  Revision: 1.0
// ============================================================================
package mips_pkg;

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_bne   = 6'b000101;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;

    localparam logic [5:0] c_fn_add   = 6'b100000;
    localparam logic [5:0] c_fn_mult  = 6'b011000;
    localparam logic [5:0] c_fn_multu = 6'b011001;
    localparam logic [5:0] c_fn_div   = 6'b011010;
    localparam logic [5:0] c_fn_divu  = 6'b011011;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MD_WAIT = 2'd1,
        ST_MD_REL  = 2'd2
    } hsu_state_t;

    // For addi/lw the rt field names a destination, so it never creates a read hazard.
    function automatic logic op_uses_rt(input logic [5:0] op);
        return (op == c_op_rtype) || (op == c_op_beq) ||
               (op == c_op_bne)   || (op == c_op_sw);
    endfunction

    function automatic logic op_is_br(input logic [5:0] op);
        return (op == c_op_beq) || (op == c_op_bne);
    endfunction

    function automatic logic op_is_md(input logic [5:0] op, input logic [5:0] fn);
        return (op == c_op_rtype) && (fn[5:2] == c_fn_mult[5:2]);
    endfunction

    function automatic logic reg_match(input logic [4:0] r, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic uses_rt);
        return (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_stall_unit_if.sv
`default_nettype none
// ============================================================================
//  hazard_stall_unit_if
//  Pipeline-register view consumed by the hazard unit and the controls it returns.
//  Revision: 1.0
// ============================================================================
interface hazard_stall_unit_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       IF_ID_OPcode;
    logic [5:0]       IF_ID_Funct;
    logic [4:0]       IF_ID_rs;
    logic [4:0]       IF_ID_rt;
    logic             ID_EX_MemRead;
    logic             ID_EX_RegWrite;
    logic [4:0]       ID_EX_rt;
    logic [4:0]       ID_EX_dst;
    logic             EX_MEM_MemRead;
    logic [4:0]       EX_MEM_rt;
    logic             Branch_Taken;
    logic             Jump;

    logic             PC_Write;
    logic             IF_ID_Write;
    logic             IF_ID_Flush;
    logic             ID_EX_Flush;
    logic             Stall;
    logic [CNT_W-1:0] Stall_Count;

    modport master (
        output IF_ID_OPcode, IF_ID_Funct, IF_ID_rs, IF_ID_rt,
               ID_EX_MemRead, ID_EX_RegWrite, ID_EX_rt, ID_EX_dst,
               EX_MEM_MemRead, EX_MEM_rt, Branch_Taken, Jump,
        input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Stall, Stall_Count
    );

    modport slave (
        input  IF_ID_OPcode, IF_ID_Funct, IF_ID_rs, IF_ID_rt,
               ID_EX_MemRead, ID_EX_RegWrite, ID_EX_rt, ID_EX_dst,
               EX_MEM_MemRead, EX_MEM_rt, Branch_Taken, Jump,
        output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Stall, Stall_Count
    );

endinterface
`default_nettype wire

// File: rtl/hazard_stall_unit_sat_counter.sv
`default_nettype none
// ============================================================================
//  sat_counter
//  Up-counter that sticks at all-ones instead of wrapping; async active-low clear.
//  Revision: 1.0
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_inc,
    output logic [WIDTH-1:0]      o_count
);

    localparam logic [WIDTH-1:0] c_max = {WIDTH{1'b1}};

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != c_max)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
//  hazard_stall_unit
//  Decode-stage stall/flush control: load-use, ID-branch operand and MULT/DIV hold.
//  Revision: 1.0
// ============================================================================
module hazard_stall_unit
    import mips_pkg::*;
#(
    parameter int MD_LAT = 8,
    parameter int CNT_W  = 32
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    hazard_stall_unit_if.slave  bus
);

    localparam int c_md_cnt_w = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
    localparam logic [c_md_cnt_w-1:0] c_md_load = c_md_cnt_w'(MD_LAT - 1);

    hsu_state_t              r_state;
    hsu_state_t              w_state_next;
    logic [c_md_cnt_w-1:0]   r_md_cnt;
    logic [c_md_cnt_w-1:0]   w_md_cnt_next;

    logic w_uses_rt;
    logic w_is_br;
    logic w_is_md;
    logic w_lu;
    logic w_br;
    logic w_haz;
    logic w_stall;
    logic w_if_id_flush;
    logic [CNT_W-1:0] w_stall_count;

    assign w_uses_rt = op_uses_rt(bus.IF_ID_OPcode);
    assign w_is_br   = op_is_br(bus.IF_ID_OPcode);
    assign w_is_md   = op_is_md(bus.IF_ID_OPcode, bus.IF_ID_Funct);

    assign w_lu  = bus.ID_EX_MemRead &
                   reg_match(bus.ID_EX_rt, bus.IF_ID_rs, bus.IF_ID_rt, w_uses_rt);
    // A branch resolved in ID needs its operands now: an ALU result still in EX
    // or a load still in MEM cannot reach the ID comparator in time.
    assign w_br  = w_is_br &
                   ((bus.ID_EX_RegWrite &
                     reg_match(bus.ID_EX_dst, bus.IF_ID_rs, bus.IF_ID_rt, w_uses_rt)) |
                    (bus.EX_MEM_MemRead &
                     reg_match(bus.EX_MEM_rt, bus.IF_ID_rs, bus.IF_ID_rt, w_uses_rt)));
    assign w_haz = w_lu | w_br;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_RUN;
            r_md_cnt <= '0;
        end else begin
            r_state  <= w_state_next;
            r_md_cnt <= w_md_cnt_next;
        end
    end

    // Detection is masked while reset is asserted so the pipeline sees free-running defaults.
    always_comb begin
        w_state_next  = r_state;
        w_md_cnt_next = r_md_cnt;
        w_stall       = 1'b0;
        w_if_id_flush = 1'b0;
        if (rst_n) begin
            case (r_state)
                ST_RUN: begin
                    if (w_haz) begin
                        w_stall = 1'b1;
                    end else if (w_is_md) begin
                        w_stall = 1'b1;
                        if (MD_LAT == 1) begin
                            w_state_next = ST_MD_REL;
                        end else begin
                            w_state_next  = ST_MD_WAIT;
                            w_md_cnt_next = c_md_load;
                        end
                    end else begin
                        w_if_id_flush = bus.Branch_Taken | bus.Jump;
                    end
                end
                ST_MD_WAIT: begin
                    // The RUN entry cycle already stalled once, so leave as the count hits zero.
                    w_stall       = 1'b1;
                    w_md_cnt_next = r_md_cnt - 1'b1;
                    if (r_md_cnt <= c_md_cnt_w'(1)) begin
                        w_state_next  = ST_MD_REL;
                        w_md_cnt_next = '0;
                    end
                end
                ST_MD_REL: begin
                    w_state_next = ST_RUN;
                end
                default: begin
                    w_state_next  = ST_RUN;
                    w_md_cnt_next = '0;
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH   (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_stall),
        .o_count (w_stall_count)
    );

    assign bus.PC_Write    = ~w_stall;
    assign bus.IF_ID_Write = ~w_stall;
    assign bus.ID_EX_Flush = w_stall;
    assign bus.IF_ID_Flush = w_if_id_flush;
    assign bus.Stall       = w_stall;
    assign bus.Stall_Count = w_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
`default_nettype none
// ============================================================================
//  tb_hazard_stall_unit
//  Directed checks of two configurations: (MD_LAT=4, CNT_W=32) and (MD_LAT=1, CNT_W=4).
//  Revision: 1.0
// ============================================================================
module tb_hazard_stall_unit;
    import mips_pkg::*;

    // Flag vector order: {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Stall}
    localparam logic [4:0] c_f_run   = 5'b11000;
    localparam logic [4:0] c_f_stall = 5'b00011;
    localparam logic [4:0] c_f_flush = 5'b11100;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    hazard_stall_unit_if #(.CNT_W(32)) ifa ();
    hazard_stall_unit_if #(.CNT_W(4))  ifb ();

    hazard_stall_unit #(.MD_LAT(4), .CNT_W(32)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    hazard_stall_unit #(.MD_LAT(1), .CNT_W(4))  dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    logic [4:0] fa;
    logic [4:0] fb;
    assign fa = {ifa.PC_Write, ifa.IF_ID_Write, ifa.IF_ID_Flush, ifa.ID_EX_Flush, ifa.Stall};
    assign fb = {ifb.PC_Write, ifb.IF_ID_Write, ifb.IF_ID_Flush, ifb.ID_EX_Flush, ifb.Stall};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic id_a(input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] rs, input logic [4:0] rt);
        ifa.IF_ID_OPcode = op;
        ifa.IF_ID_Funct  = fn;
        ifa.IF_ID_rs     = rs;
        ifa.IF_ID_rt     = rt;
    endtask

    task automatic ex_a(input logic mr, input logic rw, input logic [4:0] rt, input logic [4:0] dst);
        ifa.ID_EX_MemRead  = mr;
        ifa.ID_EX_RegWrite = rw;
        ifa.ID_EX_rt       = rt;
        ifa.ID_EX_dst      = dst;
    endtask

    task automatic mem_a(input logic mr, input logic [4:0] rt);
        ifa.EX_MEM_MemRead = mr;
        ifa.EX_MEM_rt      = rt;
    endtask

    task automatic ctl_a(input logic bt, input logic j);
        ifa.Branch_Taken = bt;
        ifa.Jump         = j;
    endtask

    task automatic id_b(input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] rs, input logic [4:0] rt);
        ifb.IF_ID_OPcode = op;
        ifb.IF_ID_Funct  = fn;
        ifb.IF_ID_rs     = rs;
        ifb.IF_ID_rt     = rt;
    endtask

    task automatic ex_b(input logic mr, input logic rw, input logic [4:0] rt, input logic [4:0] dst);
        ifb.ID_EX_MemRead  = mr;
        ifb.ID_EX_RegWrite = rw;
        ifb.ID_EX_rt       = rt;
        ifb.ID_EX_dst      = dst;
    endtask

    initial begin
        rst_n = 1'b0;
        id_a(c_op_rtype, c_fn_add, 5'd0, 5'd0);
        ex_a(1'b0, 1'b0, 5'd0, 5'd0);
        mem_a(1'b0, 5'd0);
        ctl_a(1'b0, 1'b0);
        id_b(c_op_rtype, c_fn_add, 5'd0, 5'd0);
        ex_b(1'b0, 1'b0, 5'd0, 5'd0);
        ifb.EX_MEM_MemRead = 1'b0;
        ifb.EX_MEM_rt      = 5'd0;
        ifb.Branch_Taken   = 1'b0;
        ifb.Jump           = 1'b0;

        // Reset with a live load-use pattern: detection must be masked.
        ex_a(1'b1, 1'b1, 5'd2, 5'd2);
        id_a(c_op_rtype, c_fn_add, 5'd2, 5'd6);
        sample();
        chk("rst_flags_a", 32'(fa), 32'(c_f_run));
        chk("rst_cnt_a", ifa.Stall_Count, 32'd0);
        chk("rst_flags_b", 32'(fb), 32'(c_f_run));
        chk("rst_cnt_b", 32'(ifb.Stall_Count), 32'd0);

        tick(); rst_n = 1'b1;
        sample();
        chk("lu_stall", 32'(fa), 32'(c_f_stall));
        chk("lu_cnt0", ifa.Stall_Count, 32'd0);

        tick(); ex_a(1'b0, 1'b0, 5'd0, 5'd0);
        sample();
        chk("lu_clear", 32'(fa), 32'(c_f_run));
        chk("lu_cnt1", ifa.Stall_Count, 32'd1);

        tick(); ex_a(1'b1, 1'b0, 5'd0, 5'd0); id_a(c_op_rtype, c_fn_add, 5'd0, 5'd0);
        sample();
        chk("lu_r0", 32'(fa), 32'(c_f_run));

        tick(); ex_a(1'b1, 1'b0, 5'd5, 5'd0); id_a(c_op_sw, 6'd0, 5'd1, 5'd5);
        sample();
        chk("lu_sw_rt", 32'(fa), 32'(c_f_stall));

        tick(); id_a(c_op_addi, 6'd0, 5'd1, 5'd5);
        sample();
        chk("lu_addi_rt", 32'(fa), 32'(c_f_run));
        chk("cnt_after_sw", ifa.Stall_Count, 32'd2);

        tick(); ex_a(1'b0, 1'b1, 5'd0, 5'd3); id_a(c_op_beq, 6'd0, 5'd3, 5'd4);
        sample();
        chk("br_ex", 32'(fa), 32'(c_f_stall));

        tick(); ex_a(1'b1, 1'b1, 5'd3, 5'd3);
        sample();
        chk("lw_beq_1", 32'(fa), 32'(c_f_stall));

        tick(); ex_a(1'b0, 1'b0, 5'd0, 5'd0); mem_a(1'b1, 5'd3);
        sample();
        chk("lw_beq_2", 32'(fa), 32'(c_f_stall));
        chk("cnt_lw_beq", ifa.Stall_Count, 32'd4);

        tick(); mem_a(1'b0, 5'd0); ctl_a(1'b1, 1'b0);
        sample();
        chk("bt_flush", 32'(fa), 32'(c_f_flush));
        chk("cnt_br", ifa.Stall_Count, 32'd5);

        tick(); ex_a(1'b0, 1'b1, 5'd0, 5'd3);
        sample();
        chk("bt_haz_noflush", 32'(fa), 32'(c_f_stall));

        tick(); ex_a(1'b0, 1'b0, 5'd0, 5'd0); ctl_a(1'b0, 1'b1); id_a(c_op_rtype, c_fn_add, 5'd0, 5'd0);
        sample();
        chk("jump_flush", 32'(fa), 32'(c_f_flush));

        // DIV held for MD_LAT=4 stall cycles, then one release cycle.
        tick(); ctl_a(1'b0, 1'b0); id_a(c_op_rtype, c_fn_div, 5'd8, 5'd9);
        sample();
        chk("md_c1", 32'(fa), 32'(c_f_stall));
        chk("md_cnt_start", ifa.Stall_Count, 32'd6);
        tick(); sample(); chk("md_c2", 32'(fa), 32'(c_f_stall));
        tick(); sample(); chk("md_c3", 32'(fa), 32'(c_f_stall));
        tick(); sample(); chk("md_c4", 32'(fa), 32'(c_f_stall));
        tick(); ctl_a(1'b1, 1'b0);
        sample();
        chk("md_rel", 32'(fa), 32'(c_f_run));
        chk("md_cnt_end", ifa.Stall_Count, 32'd10);

        tick(); ctl_a(1'b0, 1'b0); id_a(c_op_rtype, c_fn_add, 5'd0, 5'd0);
        sample();
        chk("md_after", 32'(fa), 32'(c_f_run));
        chk("md_cnt_hold", ifa.Stall_Count, 32'd10);

        // Reset asserted in the second stalled cycle of a DIV.
        tick(); id_a(c_op_rtype, c_fn_divu, 5'd8, 5'd9);
        sample();
        chk("rmd_c1", 32'(fa), 32'(c_f_stall));
        tick(); sample();
        chk("rmd_c2", 32'(fa), 32'(c_f_stall));
        chk("rmd_cnt", ifa.Stall_Count, 32'd11);
        #1 rst_n = 1'b0;
        #1;
        chk("rmd_async_flags", 32'(fa), 32'(c_f_run));
        chk("rmd_async_cnt", ifa.Stall_Count, 32'd0);
        id_a(c_op_rtype, c_fn_add, 5'd0, 5'd0);

        tick(); rst_n = 1'b1;
        sample();
        chk("rmd_released", 32'(fa), 32'(c_f_run));
        tick(); ctl_a(1'b1, 1'b0);
        sample();
        chk("rmd_in_run", 32'(fa), 32'(c_f_flush));
        chk("rmd_cnt_zero", ifa.Stall_Count, 32'd0);
        tick(); ctl_a(1'b0, 1'b0);

        // MD_LAT=1: exactly one stall, then release without re-trigger.
        id_b(c_op_rtype, c_fn_mult, 5'd1, 5'd2);
        sample();
        chk("b_md_c1", 32'(fb), 32'(c_f_stall));
        chk("b_cnt0", 32'(ifb.Stall_Count), 32'd0);
        tick(); sample();
        chk("b_md_rel", 32'(fb), 32'(c_f_run));
        chk("b_cnt1", 32'(ifb.Stall_Count), 32'd1);
        tick(); id_b(c_op_rtype, c_fn_add, 5'd0, 5'd0);
        sample();
        chk("b_after", 32'(fb), 32'(c_f_run));

        // 20 further stall cycles on a 4-bit counter: 1 + 20 saturates at 15.
        ex_b(1'b1, 1'b0, 5'd7, 5'd0); id_b(c_op_rtype, c_fn_add, 5'd7, 5'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 9) chk("b_cnt_mid", 32'(ifb.Stall_Count), 32'd11);
        end
        ex_b(1'b0, 1'b0, 5'd0, 5'd0);
        sample();
        chk("b_sat_flags", 32'(fb), 32'(c_f_run));
        chk("b_sat_cnt", 32'(ifb.Stall_Count), 32'd15);
        chk("a_cnt_idle", ifa.Stall_Count, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
